// File: rtl/admission_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : admission_ctrl_pkg
// Description : Shared definitions for the admission controller: queue count,
//               port-index and length widths, the controller FSM state type
//               and a round-robin pointer increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package admission_ctrl_pkg;

  localparam int c_NUM_Q  = 4;   // number of egress queues
  localparam int c_PORT_W = 4;   // width of a descriptor port index
  localparam int c_LEN_W  = 11;  // width of a descriptor byte length
  localparam int c_PTR_W  = 2;   // width of a queue index (0..c_NUM_Q-1)

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECIDE  = 2'd1,
    ST_HD_WAIT = 2'd2
  } state_t;

  // Next round-robin position; the natural width overflow wraps 3 -> 0.
  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] idx);
    return idx + c_PTR_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/admission_ctrl_rr_victim_sel.sv
`default_nettype none
// ============================================================================
// Module      : rr_victim_sel
// Description : Purely combinational round-robin pick. Returns the first
//               requesting queue found scanning upward from ptr and wrapping
//               from the top index back to 0.
// Ports       : req   - per-queue candidate flags
//               ptr   - scan start position
//               grant - selected queue index (0 when valid is low)
//               valid - at least one candidate exists
// Revision    : 1.0 - initial release
// ============================================================================
module rr_victim_sel
  import admission_ctrl_pkg::*;
(
  input  logic [c_NUM_Q-1:0] req,
  input  logic [c_PTR_W-1:0] ptr,
  output logic [c_PTR_W-1:0] grant,
  output logic               valid
);

  logic [c_PTR_W-1:0] w_idx;

  // Scan from the farthest offset down to offset 0 so the candidate nearest
  // to ptr is the one left standing.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_idx = '0;
    for (int i = c_NUM_Q - 1; i >= 0; i--) begin
      w_idx = ptr + c_PTR_W'(i);
      if (req[w_idx]) begin
        grant = w_idx;
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/admission_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : admission_ctrl
// Description : Per-descriptor admission decision. A descriptor is captured in
//               IDLE, judged in a single DECIDE cycle against the statistics
//               bitmap and either accepted (in pulse) or tail-dropped (drop
//               pulse). With head drop enabled, a tail drop also asks the queue
//               manager to discard the head of a round-robin chosen victim
//               queue and waits (bounded by HD_TIMEOUT) for its acknowledge.
// Config      : `define ADMISSION_HEADDROP_EN enables head-drop; without it
//               hd_req/hd_port are tied 0 and hd_ack is ignored.
// Ports       : clk, rstn (async, active low)
//               pkt_valid/pkt_ready, pkt_port, pkt_len - descriptor handshake
//               bitmap, bitmap_dt, q_nonempty          - per-queue status
//               in, in_port, pkt_len_in                - accept event
//               drop, drop_port                        - tail-drop event
//               hd_req, hd_port, hd_ack                - head-drop handshake
//               accept_cnt, drop_cnt                   - saturating counters
// Revision    : 1.0 - initial release
// ============================================================================
module admission_ctrl
  import admission_ctrl_pkg::*;
#(
  parameter int HD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                pkt_valid,
  output logic                pkt_ready,
  input  logic [c_PORT_W-1:0] pkt_port,
  input  logic [c_LEN_W-1:0]  pkt_len,
  input  logic [c_NUM_Q-1:0]  bitmap,
  input  logic [c_NUM_Q-1:0]  bitmap_dt,
  input  logic [c_NUM_Q-1:0]  q_nonempty,
  output logic                in,
  output logic [c_PORT_W-1:0] in_port,
  output logic [c_LEN_W-1:0]  pkt_len_in,
  output logic                drop,
  output logic [c_PORT_W-1:0] drop_port,
  output logic                hd_req,
  output logic [c_PORT_W-1:0] hd_port,
  input  logic                hd_ack,
  output logic [CNT_W-1:0]    accept_cnt,
  output logic [CNT_W-1:0]    drop_cnt
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_alive;      // low during reset and the cycle of release
  logic [c_PORT_W-1:0]  r_port;
  logic [c_LEN_W-1:0]   r_len;
  logic                 r_in;
  logic                 w_in_nxt;
  logic [c_PORT_W-1:0]  r_in_port;
  logic [c_PORT_W-1:0]  w_in_port_nxt;
  logic [c_LEN_W-1:0]   r_len_out;
  logic [c_LEN_W-1:0]   w_len_out_nxt;
  logic                 r_drop;
  logic                 w_drop_nxt;
  logic [c_PORT_W-1:0]  r_drop_port;
  logic [c_PORT_W-1:0]  w_drop_port_nxt;
  logic [CNT_W-1:0]     r_acc_cnt;
  logic [CNT_W-1:0]     r_drop_cnt;
  logic                 w_cap;
  logic                 w_port_ok;
  logic                 w_admit;

  // Ports 4..15 name no real queue: always dropped, never a head-drop source.
  assign w_port_ok = (r_port[c_PORT_W-1:c_PTR_W] == '0);
  assign w_admit   = w_port_ok && bitmap[r_port[c_PTR_W-1:0]];

`ifdef ADMISSION_HEADDROP_EN
  localparam int                c_TO_W    = (HD_TIMEOUT > 1) ? $clog2(HD_TIMEOUT) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(HD_TIMEOUT - 1);

  logic                r_hd_req;
  logic                w_hd_req_nxt;
  logic [c_PTR_W-1:0]  r_hd_idx;
  logic [c_PTR_W-1:0]  w_hd_idx_nxt;
  logic [c_PTR_W-1:0]  r_ptr;
  logic [c_PTR_W-1:0]  w_ptr_nxt;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic [c_TO_W-1:0]   w_to_nxt;
  logic [c_NUM_Q-1:0]  w_victim_req;
  logic [c_PTR_W-1:0]  w_grant;
  logic                w_grant_vld;

  // A victim must be over its drop threshold and actually hold a packet.
  assign w_victim_req = ~bitmap_dt & q_nonempty;

  rr_victim_sel u_victim_sel (
    .req   (w_victim_req),
    .ptr   (r_ptr),
    .grant (w_grant),
    .valid (w_grant_vld)
  );

  assign hd_req  = r_hd_req;
  assign hd_port = {{(c_PORT_W - c_PTR_W){1'b0}}, r_hd_idx};
`else
  logic w_unused_hd;
  assign w_unused_hd = &{1'b0, hd_ack, bitmap_dt, q_nonempty, 32'(HD_TIMEOUT)};

  assign hd_req  = 1'b0;
  assign hd_port = '0;
`endif

  assign pkt_ready  = r_alive && (r_state == ST_IDLE);
  assign in         = r_in;
  assign in_port    = r_in_port;
  assign pkt_len_in = r_len_out;
  assign drop       = r_drop;
  assign drop_port  = r_drop_port;
  assign accept_cnt = r_acc_cnt;
  assign drop_cnt   = r_drop_cnt;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and next values of the registered event outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_cap           = 1'b0;
    w_in_nxt        = 1'b0;
    w_in_port_nxt   = r_in_port;
    w_len_out_nxt   = r_len_out;
    w_drop_nxt      = 1'b0;
    w_drop_port_nxt = r_drop_port;
`ifdef ADMISSION_HEADDROP_EN
    w_hd_req_nxt    = 1'b0;
    w_hd_idx_nxt    = r_hd_idx;
    w_ptr_nxt       = r_ptr;
    w_to_nxt        = r_to_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (pkt_valid && r_alive) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        w_state_nxt = ST_IDLE;
        if (w_admit) begin
          w_in_nxt      = 1'b1;
          w_in_port_nxt = r_port;
          w_len_out_nxt = r_len;
        end else begin
          w_drop_nxt      = 1'b1;
          w_drop_port_nxt = r_port;
`ifdef ADMISSION_HEADDROP_EN
          if (w_port_ok && w_grant_vld) begin
            w_hd_req_nxt = 1'b1;
            w_hd_idx_nxt = w_grant;
            w_ptr_nxt    = ptr_inc(w_grant);
            w_to_nxt     = '0;
            w_state_nxt  = ST_HD_WAIT;
          end
`endif
        end
      end
      ST_HD_WAIT: begin
`ifdef ADMISSION_HEADDROP_EN
        // r_to_cnt counts request cycles already spent; the last allowed one
        // is HD_TIMEOUT-1, so hd_req is high for at most HD_TIMEOUT cycles.
        if (hd_ack || (r_to_cnt == c_TO_LAST)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_hd_req_nxt = 1'b1;
          w_to_nxt     = r_to_cnt + c_TO_W'(1);
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Descriptor capture, event outputs and saturating counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_alive     <= 1'b0;
      r_port      <= '0;
      r_len       <= '0;
      r_in        <= 1'b0;
      r_in_port   <= '0;
      r_len_out   <= '0;
      r_drop      <= 1'b0;
      r_drop_port <= '0;
      r_acc_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_alive     <= 1'b1;
      if (w_cap) begin
        r_port <= pkt_port;
        r_len  <= pkt_len;
      end
      r_in        <= w_in_nxt;
      r_in_port   <= w_in_port_nxt;
      r_len_out   <= w_len_out_nxt;
      r_drop      <= w_drop_nxt;
      r_drop_port <= w_drop_port_nxt;
      if (w_in_nxt && (r_acc_cnt != {CNT_W{1'b1}})) begin
        r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      end
      if (w_drop_nxt && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

`ifdef ADMISSION_HEADDROP_EN
  // --------------------------------------------------------------------------
  // Head-drop request, round-robin pointer and wait timer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hd_req <= 1'b0;
      r_hd_idx <= '0;
      r_ptr    <= '0;
      r_to_cnt <= '0;
    end else begin
      r_hd_req <= w_hd_req_nxt;
      r_hd_idx <= w_hd_idx_nxt;
      r_ptr    <= w_ptr_nxt;
      r_to_cnt <= w_to_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/admission_ctrl.md
ADMISSION_CTRL -- requirements
Module: admission_ctrl

Interface
REQ-001 SHALL have parameter HD_TIMEOUT, default 64, max cycles to wait for hd_ack.
REQ-002 SHALL have parameter CNT_W, default 32, width of the accept and drop counters.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 pkt_valid / pkt_ready  input / output  1 / 1  arriving-descriptor handshake.
REQ-006 pkt_port / pkt_len  input  4 / 11  descriptor queue index (0..3) and byte length.
REQ-007 bitmap / bitmap_dt  input  4 / 4  per-queue below-threshold flags from the statistics stage.
REQ-008 q_nonempty  input  4  per-queue non-empty flags from the queue manager.
REQ-009 in / in_port / pkt_len_in  output  1 / 4 / 11  accept pulse, queue index and length to statistics.
REQ-010 drop / drop_port  output  1 / 4  tail-drop pulse and queue index.
REQ-011 hd_req / hd_port / hd_ack  output / output / input  1 / 4 / 1  head-drop request handshake to the queue manager.
REQ-012 accept_cnt / drop_cnt  output  CNT_W / CNT_W  saturating event counters.

Function
REQ-013 SHALL implement the FSM IDLE -> DECIDE -> (IDLE | HD_WAIT), with HD_WAIT -> IDLE.
REQ-014 pkt_ready SHALL be 1 only in IDLE; a descriptor is captured on pkt_valid&&pkt_ready, moving to DECIDE.
REQ-015 DECIDE SHALL last exactly one cycle and sample bitmap/bitmap_dt/q_nonempty in that cycle.
REQ-016 If bitmap[captured port]==1, SHALL register in=1, in_port, pkt_len_in for exactly one cycle, visible the cycle after DECIDE (handshake edge +2), and return to IDLE.
REQ-017 Else SHALL register drop=1, drop_port for one cycle at the same timing.
REQ-018 On a tail drop, SHALL select a victim: the lowest-index queue at or after the round-robin pointer with bitmap_dt==0 and q_nonempty==1, wrapping from 3 to 0.
REQ-019 If a victim exists, SHALL assert hd_req with hd_port=victim from the cycle after DECIDE, enter HD_WAIT, and advance the pointer to victim+1 mod 4.
REQ-020 If no victim exists, SHALL return to IDLE with the pointer unchanged.
REQ-021 hd_req SHALL stay high and hd_port stable until hd_ack is sampled high, then deassert the next cycle and go to IDLE.
REQ-022 If hd_ack is absent for HD_TIMEOUT cycles in HD_WAIT, SHALL deassert hd_req and go to IDLE with no other side effect.
REQ-023 hd_ack outside HD_WAIT SHALL be ignored.
REQ-024 Throughput SHALL be one descriptor per 2 cycles when no head drop occurs.
REQ-025 accept_cnt SHALL increment per in pulse and drop_cnt per drop pulse, each saturating at all-ones with no wrap.
REQ-026 pkt_port values 4..15 SHALL be treated as dropped with no head drop triggered.
REQ-027 in, drop and hd_req SHALL never be high in the same cycle except drop with hd_req on the first HD_WAIT cycle.

Reset
REQ-028 On rstn low, SHALL immediately go to IDLE and clear all outputs to 0 (pkt_ready becomes 1 after release), with counters 0 and round-robin pointer 0.
REQ-029 Reset during HD_WAIT SHALL abandon the request with hd_req low; no pending request is retained.

Configuration
REQ-030 With macro ADMISSION_HEADDROP_EN defined, REQ-018..REQ-023 SHALL be active.
REQ-031 Without ADMISSION_HEADDROP_EN, hd_req and hd_port SHALL be held 0, HD_WAIT is unreachable, and hd_ack is unused.

Structure
REQ-032 Shared package SHALL hold the FSM state enum, the port-index width (4), the length width (11) and the number of queues (4).
REQ-033 Victim selection SHALL be a sub-module rr_victim_sel: 4-bit request in, pointer in, grant index and valid out, purely combinational.

Verification
REQ-034 Accept: bitmap=4'b1111, descriptor port 2 / len 100 -> in=1, in_port=2, pkt_len_in=100 at handshake+2; accept_cnt=1.
REQ-035 Tail drop, no victim: bitmap=0, bitmap_dt=4'b1111, port 1 -> drop=1, drop_port=1, hd_req stays 0.
REQ-036 Head drop: bitmap=0, bitmap_dt=4'b0101, q_nonempty=4'b1111, pointer 0 -> hd_port=1; hd_ack after 3 cycles -> hd_req low next cycle; a second drop then selects queue 3.
REQ-037 Timeout: victim chosen, hd_ack never asserted -> hd_req low after 64 cycles, pkt_ready back to 1.
REQ-038 Saturation: preload drop_cnt to all-ones, force a drop -> drop_cnt unchanged.
REQ-039 Reset mid HD_WAIT: rstn low for 1 cycle -> hd_req=0, pkt_ready=1 after release, counters 0.
